// File: rtl/piano_link_pkg.sv
// piano_link_pkg
// Shared types and constants for the piano key-word serial receiver.
//   byte_state_t : byte-level UART receive FSM states
//   asm_state_t  : header/payload word assembler states
//   HDR_MARK / PAY_MARK : expected value of byte bits [7:5]
//   key_word_t   : 10-bit key word delivered to the host
// Optional build macro: PIANO_LINK_PARITY_EN adds the PARITY state.
package piano_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PIANO_LINK_PARITY_EN
    PARITY,
`endif
    STOP,
    REARM
  } byte_state_t;

  typedef enum logic {
    WAIT_HDR,
    WAIT_PAY
  } asm_state_t;

  localparam logic [2:0] HDR_MARK = 3'b100;
  localparam logic [2:0] PAY_MARK = 3'b000;

  typedef logic [9:0] key_word_t;

endpackage

// File: rtl/piano_link_rx_byte.sv
// piano_link_rx_byte
// Synchronizes the raw serial line and decodes 8N1 bytes (8E1 when
// PIANO_LINK_PARITY_EN is defined), LSB first.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   rxd          : raw serial line, idle high, asynchronous to clk
//   byte_data    : last shifted-in byte, valid while byte_valid is high
//   byte_valid   : single-cycle strobe in the stop-bit sample cycle (good frame)
//   byte_ferr    : single-cycle strobe in the stop-bit sample cycle (bad stop/parity)
// Optional build macro: PIANO_LINK_PARITY_EN.
module piano_link_rx_byte
  import piano_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_ferr
);

  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

  logic        rxd_meta, rxd_sync, rxd_prev;
  byte_state_t state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_ok;
`ifdef PIANO_LINK_PARITY_EN
  logic        par_q, par_d;
  // Even parity: data bits plus parity bit must hold an even number of ones.
  assign par_ok = (par_q == ^shreg_q);
`else
  assign par_ok = 1'b1;
`endif

  // Synchronizer and previous-sample flop reset to the idle (high) level so
  // that leaving reset never looks like a falling edge on an idle line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
`ifdef PIANO_LINK_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
`ifdef PIANO_LINK_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // The timer is cleared at mid-start, so every later sample taken at
  // LAST_CLK lands one full bit period later, near the centre of each bit.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
`ifdef PIANO_LINK_PARITY_EN
    par_d      = par_q;
`endif
    byte_valid = 1'b0;
    byte_ferr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rxd_prev && !rxd_sync) begin
          state_d = START;
          timer_d = '0;
        end
      end
      START: begin
        if (timer_q == HALF_BIT) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          // A line already back high at mid-start was a glitch: drop silently.
          state_d   = rxd_sync ? IDLE : DATA;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      DATA: begin
        if (timer_q == LAST_CLK) begin
          timer_d   = '0;
          shreg_d   = {rxd_sync, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef PIANO_LINK_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
`ifdef PIANO_LINK_PARITY_EN
      PARITY: begin
        if (timer_q == LAST_CLK) begin
          timer_d = '0;
          par_d   = rxd_sync;
          state_d = STOP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
`endif
      STOP: begin
        if (timer_q == LAST_CLK) begin
          timer_d = '0;
          if (rxd_sync && par_ok) begin
            byte_valid = 1'b1;
            state_d    = IDLE;
          end else begin
            byte_ferr = 1'b1;
            state_d   = REARM;
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      REARM: begin
        // Wait for the line to return high so a stuck-low line cannot
        // masquerade as a stream of start bits.
        if (rxd_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_data = shreg_q;

endmodule

// File: rtl/piano_link_rx.sv
// piano_link_rx
// Receives two-byte key words from the screen link: a header byte
// {1,00,data[9:5]} followed by a payload byte {0,00,data[4:0]}.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   rxd          : raw serial line, idle high
//   inputData    : last correctly assembled 10-bit key word (held)
//   data_valid   : one-cycle pulse when inputData updates
//   frame_err    : one-cycle pulse on a bad stop bit or bad parity
//   seq_err      : one-cycle pulse on a header/payload ordering or marker violation
// Optional build macro: PIANO_LINK_PARITY_EN (even parity bit per byte).
module piano_link_rx
  import piano_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [9:0] inputData,
  output logic       data_valid,
  output logic       frame_err,
  output logic       seq_err
);

  logic [7:0] byte_data;
  logic       byte_valid, byte_ferr;

  asm_state_t asm_q, asm_d;
  logic [4:0] hdr_q, hdr_d;
  key_word_t  word_q, word_d;
  logic       dv_d, fe_d, se_d;

  piano_link_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk       (clk),
    .reset_n   (reset_n),
    .rxd       (rxd),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ferr (byte_ferr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_q      <= WAIT_HDR;
      hdr_q      <= '0;
      word_q     <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      hdr_q      <= hdr_d;
      word_q     <= word_d;
      data_valid <= dv_d;
      frame_err  <= fe_d;
      seq_err    <= se_d;
    end
  end

  // Byte strobes are mutually exclusive, so at most one status pulse fires.
  always_comb begin
    asm_d  = asm_q;
    hdr_d  = hdr_q;
    word_d = word_q;
    dv_d   = 1'b0;
    fe_d   = 1'b0;
    se_d   = 1'b0;
    if (byte_ferr) begin
      fe_d  = 1'b1;
      asm_d = WAIT_HDR;
    end else if (byte_valid) begin
      if (byte_data[7:5] == HDR_MARK) begin
        // A repeated header replaces the pending one but is still flagged.
        hdr_d = byte_data[4:0];
        asm_d = WAIT_PAY;
        if (asm_q == WAIT_PAY) se_d = 1'b1;
      end else if (byte_data[7:5] == PAY_MARK) begin
        if (asm_q == WAIT_PAY) begin
          word_d = {hdr_q, byte_data[4:0]};
          dv_d   = 1'b1;
        end else begin
          se_d = 1'b1;
        end
        asm_d = WAIT_HDR;
      end else begin
        se_d  = 1'b1;
        asm_d = WAIT_HDR;
      end
    end
  end

  assign inputData = word_q;

endmodule

// File: tb/tb_piano_link_rx.sv
// tb_piano_link_rx
// Directed bench for piano_link_rx with CLKS_PER_BIT = 16.
// Honours PIANO_LINK_PARITY_EN for the framing it drives.
module tb_piano_link_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       reset_n;
  logic       rxd;
  logic [9:0] inputData;
  logic       data_valid, frame_err, seq_err;

  int n_checks = 0;
  int n_fail   = 0;
  int dv_cnt   = 0;
  int fe_cnt   = 0;
  int se_cnt   = 0;
  int ovl_cnt  = 0;
  int dv0, fe0, se0;

  piano_link_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rxd       (rxd),
    .inputData (inputData),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .seq_err   (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters count high cycles, so a stretched pulse shows up as extra.
  always @(negedge clk) begin
    if (data_valid) dv_cnt++;
    if (frame_err)  fe_cnt++;
    if (seq_err)    se_cnt++;
    if ((int'(data_valid) + int'(frame_err) + int'(seq_err)) > 1) ovl_cnt++;
  end

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_period(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_v, input logic stop_v);
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(b[i]);
`ifdef PIANO_LINK_PARITY_EN
    bit_period(par_v);
`else
    if (par_v) rxd = 1'b1;
`endif
    bit_period(stop_v);
    rxd = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, ^b, 1'b1);
  endtask

  task automatic snap();
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    se0 = se_cnt;
  endtask

  task automatic test_reset();
    rxd = 1'b1;
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (inputData !== 10'h000) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 000", inputData); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dv: got %b expected 0", data_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fe: got %b expected 0", frame_err); end
    n_checks++; if (seq_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_se: got %b expected 0", seq_err); end
    reset_n = 1'b1;
    idle(8);
  endtask

  task automatic test_basic_word();
    snap();
    send_byte(8'h90);
    send_byte(8'h0A);
    idle(6);
    n_checks++; if (dv_cnt - dv0 !== 1) begin n_fail++; $display("[TB] FAIL basic_dv: got %0d expected 1", dv_cnt - dv0); end
    n_checks++; if (inputData !== 10'h20A) begin n_fail++; $display("[TB] FAIL basic_data: got %h expected 20a", inputData); end
    n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("[TB] FAIL basic_fe: got %0d expected 0", fe_cnt - fe0); end
    n_checks++; if (se_cnt - se0 !== 0) begin n_fail++; $display("[TB] FAIL basic_se: got %0d expected 0", se_cnt - se0); end
  endtask

  task automatic test_orphan_payload();
    snap();
    send_byte(8'h05);
    idle(6);
    n_checks++; if (se_cnt - se0 !== 1) begin n_fail++; $display("[TB] FAIL orphan_se: got %0d expected 1", se_cnt - se0); end
    n_checks++; if (dv_cnt - dv0 !== 0) begin n_fail++; $display("[TB] FAIL orphan_dv: got %0d expected 0", dv_cnt - dv0); end
    n_checks++; if (inputData !== 10'h20A) begin n_fail++; $display("[TB] FAIL orphan_data: got %h expected 20a", inputData); end
  endtask

  task automatic test_frame_error();
    snap();
    send_frame(8'h81, ^8'h81, 1'b0);
    idle(6);
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("[TB] FAIL ferr_fe: got %0d expected 1", fe_cnt - fe0); end
    n_checks++; if (dv_cnt - dv0 !== 0) begin n_fail++; $display("[TB] FAIL ferr_dv: got %0d expected 0", dv_cnt - dv0); end
    snap();
    send_byte(8'h82);
    send_byte(8'h03);
    idle(6);
    n_checks++; if (inputData !== 10'h043) begin n_fail++; $display("[TB] FAIL ferr_recover_data: got %h expected 043", inputData); end
    n_checks++; if (dv_cnt - dv0 !== 1) begin n_fail++; $display("[TB] FAIL ferr_recover_dv: got %0d expected 1", dv_cnt - dv0); end
    n_checks++; if (se_cnt - se0 + fe_cnt - fe0 !== 0) begin n_fail++; $display("[TB] FAIL ferr_recover_err: got %0d expected 0", se_cnt - se0 + fe_cnt - fe0); end
  endtask

  task automatic test_glitch();
    snap();
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * CPB);
    n_checks++; if (dv_cnt - dv0 !== 0) begin n_fail++; $display("[TB] FAIL glitch_dv: got %0d expected 0", dv_cnt - dv0); end
    n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("[TB] FAIL glitch_fe: got %0d expected 0", fe_cnt - fe0); end
    n_checks++; if (se_cnt - se0 !== 0) begin n_fail++; $display("[TB] FAIL glitch_se: got %0d expected 0", se_cnt - se0); end
    n_checks++; if (inputData !== 10'h043) begin n_fail++; $display("[TB] FAIL glitch_data: got %h expected 043", inputData); end
  endtask

  task automatic test_header_replace();
    snap();
    send_byte(8'h81);
    send_byte(8'h85);
    send_byte(8'h02);
    idle(6);
    n_checks++; if (se_cnt - se0 !== 1) begin n_fail++; $display("[TB] FAIL hdr_replace_se: got %0d expected 1", se_cnt - se0); end
    n_checks++; if (dv_cnt - dv0 !== 1) begin n_fail++; $display("[TB] FAIL hdr_replace_dv: got %0d expected 1", dv_cnt - dv0); end
    n_checks++; if (inputData !== 10'h0A2) begin n_fail++; $display("[TB] FAIL hdr_replace_data: got %h expected 0a2", inputData); end
  endtask

  task automatic test_marker_bits();
    snap();
    send_byte(8'h81);
    send_byte(8'hA0);
    send_byte(8'h03);
    idle(6);
    n_checks++; if (se_cnt - se0 !== 2) begin n_fail++; $display("[TB] FAIL marker_se: got %0d expected 2", se_cnt - se0); end
    n_checks++; if (dv_cnt - dv0 !== 0) begin n_fail++; $display("[TB] FAIL marker_dv: got %0d expected 0", dv_cnt - dv0); end
    n_checks++; if (inputData !== 10'h0A2) begin n_fail++; $display("[TB] FAIL marker_hold: got %h expected 0a2", inputData); end
    send_byte(8'h81);
    send_byte(8'h03);
    idle(6);
    n_checks++; if (inputData !== 10'h023) begin n_fail++; $display("[TB] FAIL marker_recover: got %h expected 023", inputData); end
  endtask

  task automatic test_back_to_back();
    snap();
    send_byte(8'h9F);
    send_byte(8'h1F);
    send_byte(8'h80);
    send_byte(8'h15);
    idle(6);
    n_checks++; if (dv_cnt - dv0 !== 2) begin n_fail++; $display("[TB] FAIL b2b_dv: got %0d expected 2", dv_cnt - dv0); end
    n_checks++; if (inputData !== 10'h015) begin n_fail++; $display("[TB] FAIL b2b_data: got %h expected 015", inputData); end
    n_checks++; if (se_cnt - se0 + fe_cnt - fe0 !== 0) begin n_fail++; $display("[TB] FAIL b2b_err: got %0d expected 0", se_cnt - se0 + fe_cnt - fe0); end
  endtask

  task automatic test_reset_mid_word();
    send_byte(8'h9F);
    bit_period(1'b0);
    bit_period(1'b1);
    bit_period(1'b0);
    reset_n = 1'b0;
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (inputData !== 10'h000) begin n_fail++; $display("[TB] FAIL midrst_clear: got %h expected 000", inputData); end
    reset_n = 1'b1;
    idle(8);
    snap();
    send_byte(8'h01);
    idle(6);
    n_checks++; if (se_cnt - se0 !== 1) begin n_fail++; $display("[TB] FAIL midrst_hdr_dropped: got %0d expected 1", se_cnt - se0); end
    snap();
    send_byte(8'h81);
    send_byte(8'h01);
    idle(6);
    n_checks++; if (inputData !== 10'h021) begin n_fail++; $display("[TB] FAIL midrst_data: got %h expected 021", inputData); end
    n_checks++; if (dv_cnt - dv0 !== 1) begin n_fail++; $display("[TB] FAIL midrst_dv: got %0d expected 1", dv_cnt - dv0); end
  endtask

`ifdef PIANO_LINK_PARITY_EN
  task automatic test_parity();
    snap();
    send_frame(8'h90, ~(^8'h90), 1'b1);
    idle(6);
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("[TB] FAIL parity_bad_fe: got %0d expected 1", fe_cnt - fe0); end
    n_checks++; if (dv_cnt - dv0 !== 0) begin n_fail++; $display("[TB] FAIL parity_bad_dv: got %0d expected 0", dv_cnt - dv0); end
    send_byte(8'h90);
    send_byte(8'h0A);
    idle(6);
    n_checks++; if (inputData !== 10'h20A) begin n_fail++; $display("[TB] FAIL parity_good_data: got %h expected 20a", inputData); end
  endtask
`endif

  task automatic test_exclusive();
    n_checks++; if (ovl_cnt !== 0) begin n_fail++; $display("[TB] FAIL pulse_overlap: got %0d expected 0", ovl_cnt); end
  endtask

  initial begin
    rxd = 1'b1;
    reset_n = 1'b1;
    test_reset();
    test_basic_word();
    test_orphan_payload();
    test_frame_error();
    test_glitch();
    test_header_replace();
    test_marker_bits();
    test_back_to_back();
    test_reset_mid_word();
`ifdef PIANO_LINK_PARITY_EN
    test_parity();
`endif
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
